// File: rtl/mem_wb_sram_stage.sv
// Memory + write-back stage: LDR/STR over a 16-bit SRAM as two half-word
// accesses (low half, then high half), followed by the register-file write port.
module mem_wb_sram_stage #(
    parameter int N           = 32,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         WB_ENIn,
    input  logic         MEM_R_ENIn,
    input  logic         MEM_W_ENIn,
    input  logic [N-1:0] ALU_ResIn,
    input  logic [N-1:0] Val_RmIn,
    input  logic [3:0]   DestIn,
    output logic         freezeOut,
    output logic         WB_ENOut,
    output logic [3:0]   WB_DestOut,
    output logic [N-1:0] WB_ValueOut,
    output logic [17:0]  SRAM_ADDROut,
    output logic         SRAM_WE_NOut,
    output logic [15:0]  SRAM_DQOut,
    output logic         SRAM_DQ_OEOut,
    input  logic [15:0]  SRAM_DQIn
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    localparam logic [31:0] BASE_W    = 32'(BASE_ADDR);
    localparam logic [2:0]  WAIT_LAST = 3'(WAIT_CYCLES);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [15:0]   lo_q, lo_d;
    logic [15:0]   hi_q, hi_d;
    logic          wb_en_q, wb_en_d;
    logic [3:0]    wb_dest_q, wb_dest_d;
    logic [N-1:0]  wb_value_q, wb_value_d;
    logic [17:0]   sram_addr_q, sram_addr_d;
    logic          sram_we_n_q, sram_we_n_d;
    logic [15:0]   sram_dq_q, sram_dq_d;
    logic          sram_oe_q, sram_oe_d;

    logic          mem;
    logic          is_store;
    logic          freeze;
    logic [16:0]   word;

    assign mem      = MEM_R_ENIn | MEM_W_ENIn;
    assign is_store = MEM_W_ENIn & ~MEM_R_ENIn;
    assign freeze   = mem & (state_q != S_DONE);

    // Bits [18:2] of (ALU_ResIn - BASE_ADDR), with the borrow out of the low two bits.
    assign word = ALU_ResIn[18:2] - BASE_W[18:2] - 17'(ALU_ResIn[1:0] < BASE_W[1:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (mem) state_d = S_LO;
            end
            S_LO: begin
                if (cnt_q == WAIT_LAST) begin
                    lo_d    = SRAM_DQIn;
                    cnt_d   = '0;
                    state_d = S_HI;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HI: begin
                if (cnt_q == WAIT_LAST) begin
                    hi_d    = SRAM_DQIn;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // SRAM pins are registered from the next state so they line up with it.
    always_comb begin
        sram_addr_d = '0;
        sram_we_n_d = 1'b1;
        sram_dq_d   = '0;
        sram_oe_d   = 1'b0;
        if (state_d == S_LO || state_d == S_HI) begin
            sram_addr_d = {word, (state_d == S_HI)};
            if (is_store) begin
                sram_we_n_d = 1'b0;
                sram_oe_d   = 1'b1;
                sram_dq_d   = (state_d == S_HI) ? Val_RmIn[31:16] : Val_RmIn[15:0];
            end
        end
    end

    // A frozen cycle loads a bubble so a held instruction never writes back twice.
    always_comb begin
        wb_en_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_value_d = wb_value_q;
        if (!freeze) begin
            wb_en_d    = WB_ENIn & ~MEM_W_ENIn;
            wb_dest_d  = DestIn;
            wb_value_d = MEM_R_ENIn ? N'({hi_q, lo_q}) : ALU_ResIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            wb_en_q     <= 1'b0;
            wb_dest_q   <= '0;
            wb_value_q  <= '0;
            sram_addr_q <= '0;
            sram_we_n_q <= 1'b1;
            sram_dq_q   <= '0;
            sram_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            wb_en_q     <= wb_en_d;
            wb_dest_q   <= wb_dest_d;
            wb_value_q  <= wb_value_d;
            sram_addr_q <= sram_addr_d;
            sram_we_n_q <= sram_we_n_d;
            sram_dq_q   <= sram_dq_d;
            sram_oe_q   <= sram_oe_d;
        end
    end

    assign freezeOut     = freeze;
    assign WB_ENOut      = wb_en_q;
    assign WB_DestOut    = wb_dest_q;
    assign WB_ValueOut   = wb_value_q;
    assign SRAM_ADDROut  = sram_addr_q;
    assign SRAM_WE_NOut  = sram_we_n_q;
    assign SRAM_DQOut    = sram_dq_q;
    assign SRAM_DQ_OEOut = sram_oe_q;

endmodule

// File: tb/tb_mem_wb_sram_stage.sv
// Bench for mem_wb_sram_stage: directed cases plus random ALU/LDR/STR traffic
// against a word-level memory model; a second instance covers zero wait cycles.
module tb_mem_wb_sram_stage;

    localparam int W    = 1;
    localparam int BASE = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wb_en_in, mem_r, mem_w;
    logic [31:0] alu, val_rm;
    logic [3:0]  dest;
    logic        freeze, wb_en_o, sram_we_n, sram_oe;
    logic [3:0]  wb_dest_o;
    logic [31:0] wb_val_o;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;

    logic        wb_en_in_z, mem_r_z, mem_w_z;
    logic [31:0] alu_z, val_rm_z;
    logic [3:0]  dest_z;
    logic        freeze_z, wb_en_o_z, sram_we_n_z, sram_oe_z;
    logic [3:0]  wb_dest_o_z;
    logic [31:0] wb_val_o_z;
    logic [17:0] sram_addr_z;
    logic [15:0] sram_dq_o_z, sram_dq_i_z;

    logic [15:0] sram    [0:255];
    logic [31:0] ref_mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_sram_stage #(.N(32), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .WB_ENIn(wb_en_in), .MEM_R_ENIn(mem_r), .MEM_W_ENIn(mem_w),
        .ALU_ResIn(alu), .Val_RmIn(val_rm), .DestIn(dest), .freezeOut(freeze),
        .WB_ENOut(wb_en_o), .WB_DestOut(wb_dest_o), .WB_ValueOut(wb_val_o),
        .SRAM_ADDROut(sram_addr), .SRAM_WE_NOut(sram_we_n), .SRAM_DQOut(sram_dq_o),
        .SRAM_DQ_OEOut(sram_oe), .SRAM_DQIn(sram_dq_i)
    );

    mem_wb_sram_stage #(.N(32), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .WB_ENIn(wb_en_in_z), .MEM_R_ENIn(mem_r_z), .MEM_W_ENIn(mem_w_z),
        .ALU_ResIn(alu_z), .Val_RmIn(val_rm_z), .DestIn(dest_z), .freezeOut(freeze_z),
        .WB_ENOut(wb_en_o_z), .WB_DestOut(wb_dest_o_z), .WB_ValueOut(wb_val_o_z),
        .SRAM_ADDROut(sram_addr_z), .SRAM_WE_NOut(sram_we_n_z), .SRAM_DQOut(sram_dq_o_z),
        .SRAM_DQ_OEOut(sram_oe_z), .SRAM_DQIn(sram_dq_i_z)
    );

    // Asynchronous-read SRAM device, shared by both instances (only dut writes).
    assign sram_dq_i   = sram[sram_addr[7:0]];
    assign sram_dq_i_z = sram[sram_addr_z[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n) sram[sram_addr[7:0]] <= sram_dq_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the stage idle; returns just after
    // the edge that loads the instruction's write-back.
    task automatic run_op(input logic r, input logic w, input logic we, input logic [3:0] d,
                          input logic [31:0] a, input logic [31:0] v);
        logic        is_mem, st, h, done;
        logic [31:0] word;
        int          k;
        is_mem = r | w;
        st     = w & ~r;
        word   = (a - 32'(BASE)) >> 2;
        wb_en_in = we; mem_r = r; mem_w = w; dest = d; alu = a; val_rm = v;
        k = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!freeze) begin
                done = 1'b1;
            end else begin
                if (k == 0) begin
                    check("idle_addr", 32'(sram_addr), 32'd0);
                    check("idle_we_n", 32'(sram_we_n), 32'd1);
                end else begin
                    h = (k - 1) >= (W + 1);
                    check("bubble", 32'(wb_en_o), 32'd0);
                    check("addr", 32'(sram_addr), 32'({word[16:0], h}));
                    check("we_n", 32'(sram_we_n), st ? 32'd0 : 32'd1);
                    check("oe", 32'(sram_oe), st ? 32'd1 : 32'd0);
                    if (st) check("dq", 32'(sram_dq_o), h ? 32'(v[31:16]) : 32'(v[15:0]));
                end
                k++;
                if (k > 40) done = 1'b1;
            end
        end
        check("freeze_len", 32'(k), is_mem ? 32'(2 * W + 3) : 32'd0);
        check("rel_we_n", 32'(sram_we_n), 32'd1);
        check("rel_oe", 32'(sram_oe), 32'd0);
        @(posedge clk);
        #1;
        check("wb_en", 32'(wb_en_o), 32'(we & ~w));
        check("wb_dest", 32'(wb_dest_o), 32'(d));
        check("wb_value", wb_val_o, r ? ref_mem[word[5:0]] : a);
        if (st) ref_mem[word[5:0]] = v;
    endtask

    task automatic reset_mid_access();
        wb_en_in = 1'b1; mem_r = 1'b0; mem_w = 1'b1; dest = 4'd9;
        alu = 32'(BASE + 4 * 5); val_rm = 32'h1357_9BDF;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq", 32'(sram_dq_o), 32'd0);
        check("rst_wb_en", 32'(wb_en_o), 32'd0);
        check("rst_wb_dest", 32'(wb_dest_o), 32'd0);
        check("rst_wb_value", wb_val_o, 32'd0);
        rst = 1'b0;
        run_op(1'b0, 1'b1, 1'b1, 4'd9, 32'(BASE + 4 * 5), 32'h1357_9BDF);
    endtask

    task automatic zero_wait_load();
        int k;
        wb_en_in_z = 1'b1; mem_r_z = 1'b1; mem_w_z = 1'b0; dest_z = 4'd6;
        alu_z = 32'(BASE + 4); val_rm_z = '0;
        k = 0;
        @(negedge clk);
        while (freeze_z && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("z_freeze_len", 32'(k), 32'd3);
        @(posedge clk);
        #1;
        check("z_wb_en", 32'(wb_en_o_z), 32'd1);
        check("z_wb_dest", 32'(wb_dest_o_z), 32'd6);
        check("z_wb_value", wb_val_o_z, ref_mem[1]);
        mem_r_z = 1'b0; wb_en_in_z = 1'b0;
    endtask

    initial begin
        logic [31:0] d32;
        int          kind;
        rst = 1'b1;
        wb_en_in = 0; mem_r = 0; mem_w = 0; alu = 0; val_rm = 0; dest = 0;
        wb_en_in_z = 0; mem_r_z = 0; mem_w_z = 0; alu_z = 0; val_rm_z = 0; dest_z = 0;
        for (int i = 0; i < 64; i++) begin
            d32 = $urandom;
            if (i == 1) d32 = 32'hBEEF_CAFE;
            ref_mem[i]    = d32;
            sram[2 * i]   = d32[15:0];
            sram[2 * i + 1] = d32[31:16];
        end
        for (int i = 128; i < 256; i++) sram[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_freeze", 32'(freeze), 32'd0);
        check("reset_wb_en", 32'(wb_en_o), 32'd0);
        check("reset_wb_value", wb_val_o, 32'd0);
        check("reset_we_n", 32'(sram_we_n), 32'd1);
        check("reset_oe", 32'(sram_oe), 32'd0);
        check("reset_addr", 32'(sram_addr), 32'd0);
        rst = 1'b0;

        run_op(1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_1234, 32'd0);
        run_op(1'b1, 1'b0, 1'b1, 4'd5, 32'd1028, 32'd0);
        run_op(1'b0, 1'b0, 1'b1, 4'd4, 32'h0000_0077, 32'd0);
        run_op(1'b0, 1'b1, 1'b1, 4'd7, 32'd1032, 32'hA5A5_0F0F);
        run_op(1'b1, 1'b0, 1'b1, 4'd8, 32'd1032, 32'd0);
        run_op(1'b1, 1'b1, 1'b1, 4'd2, 32'd1032, 32'hDEAD_0000);
        reset_mid_access();
        run_op(1'b1, 1'b0, 1'b1, 4'd1, 32'(BASE + 4 * 5), 32'd0);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 7);
            d32  = 32'(BASE + 4 * $urandom_range(0, 63));
            case (kind)
                0, 1, 2: run_op(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
                3, 4:    run_op(1'b1, 1'b0, 1'($urandom), 4'($urandom), d32, $urandom);
                5, 6:    run_op(1'b0, 1'b1, 1'($urandom), 4'($urandom), d32, $urandom);
                default: run_op(1'b1, 1'b1, 1'($urandom), 4'($urandom), d32, $urandom);
            endcase
        end
        wb_en_in = 0; mem_r = 0; mem_w = 0;

        zero_wait_load();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
